// File: rtl/fcc_label_grid_mem.sv
// Label/ground-flag store for the FCC clustering grid: one write port, NUM_RD read ports,
// built-in clear sweep. Define FCC_MEM_BYPASS_EN for write-first forwarding to the read ports.
module fcc_label_grid_mem #(
  parameter int unsigned ROWS    = 30,
  parameter int unsigned COLS    = 30,
  parameter int unsigned ROW_W   = 8,
  parameter int unsigned COL_W   = 5,
  parameter int unsigned LABEL_W = 16,
  parameter int unsigned NUM_RD  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_start,
  output logic                       busy,
  output logic                       clr_done,
  input  logic                       we,
  input  logic [ROW_W-1:0]           wr_row,
  input  logic [COL_W-1:0]           wr_col,
  input  logic [LABEL_W-1:0]         wr_label,
  input  logic                       wr_is_ground,
  output logic                       wr_err,
  input  logic [NUM_RD-1:0]          rd_req,
  input  logic [NUM_RD*ROW_W-1:0]    rd_row,
  input  logic [NUM_RD*COL_W-1:0]    rd_col,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD*LABEL_W-1:0]  rd_label,
  output logic [NUM_RD-1:0]          rd_is_ground,
  output logic [NUM_RD-1:0]          rd_oob
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned IDX_W = AW + 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_idx_reg, clr_idx_next;
  logic            clr_done_reg, clr_done_next;
  logic            wr_err_reg;

  logic [LABEL_W-1:0] label_mem [DEPTH];
  logic               gnd_mem   [DEPTH];

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return IDX_W'(r) * IDX_W'(COLS) + IDX_W'(c);
  endfunction

  function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return (32'(r) < ROWS) && (32'(c) < COLS);
  endfunction

  always_comb begin
    state_next    = state_reg;
    clr_idx_next  = clr_idx_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        if (clr_idx_reg == AW'(DEPTH - 1)) begin
          state_next    = ST_IDLE;
          clr_idx_next  = '0;
          clr_done_next = 1'b1;
        end else begin
          clr_idx_next = clr_idx_reg + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_next   = ST_CLEAR;
          clr_idx_next = '0;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign clr_done = clr_done_reg;
  assign wr_err   = wr_err_reg;

  // An in-range index never sets the MSB; folding it in keeps the extra bit meaningful.
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_in, wr_ok, mem_we, mem_gnd;
  logic [AW-1:0]      mem_addr;
  logic [LABEL_W-1:0] mem_label;

  assign wr_idx    = cell_idx(wr_row, wr_col);
  assign wr_in     = in_range(wr_row, wr_col) & ~wr_idx[IDX_W-1];
  assign wr_ok     = we & ~busy & wr_in;
  assign mem_we    = busy | wr_ok;
  assign mem_addr  = busy ? clr_idx_reg : wr_idx[AW-1:0];
  assign mem_label = busy ? '0 : wr_label;
  assign mem_gnd   = busy ? 1'b0 : wr_is_ground;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      label_mem[mem_addr] <= mem_label;
      gnd_mem[mem_addr]   <= mem_gnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_idx_reg  <= '0;
      clr_done_reg <= 1'b0;
      wr_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_idx_reg  <= clr_idx_next;
      clr_done_reg <= clr_done_next;
      wr_err_reg   <= we & (busy | ~wr_in);
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ROW_W-1:0]   row_g;
    logic [COL_W-1:0]   col_g;
    logic [IDX_W-1:0]   idx_g;
    logic               in_g, en_g;
    logic               valid_reg, gnd_reg, oob_reg;
    logic [LABEL_W-1:0] label_reg;

    assign row_g = rd_row[gi*ROW_W +: ROW_W];
    assign col_g = rd_col[gi*COL_W +: COL_W];
    assign idx_g = cell_idx(row_g, col_g);
    assign in_g  = in_range(row_g, col_g) & ~idx_g[IDX_W-1];
    assign en_g  = rd_req[gi] & ~busy;

`ifdef FCC_MEM_BYPASS_EN
    logic hit_g;
    assign hit_g = wr_ok & (wr_idx == idx_g);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        label_reg <= '0;
        gnd_reg   <= 1'b0;
        oob_reg   <= 1'b0;
      end else begin
        valid_reg <= en_g;
        if (en_g) begin
          if (in_g) begin
            oob_reg <= 1'b0;
`ifdef FCC_MEM_BYPASS_EN
            if (hit_g) begin
              label_reg <= wr_label;
              gnd_reg   <= wr_is_ground;
            end else begin
              label_reg <= label_mem[idx_g[AW-1:0]];
              gnd_reg   <= gnd_mem[idx_g[AW-1:0]];
            end
`else
            label_reg <= label_mem[idx_g[AW-1:0]];
            gnd_reg   <= gnd_mem[idx_g[AW-1:0]];
`endif
          end else begin
            label_reg <= '0;
            gnd_reg   <= 1'b0;
            oob_reg   <= 1'b1;
          end
        end
      end
    end

    assign rd_valid[gi]                     = valid_reg;
    assign rd_label[gi*LABEL_W +: LABEL_W]  = label_reg;
    assign rd_is_ground[gi]                 = gnd_reg;
    assign rd_oob[gi]                       = oob_reg;
  end

endmodule

// File: tb/tb_fcc_label_grid_mem.sv
// Directed bench for fcc_label_grid_mem: clear sweep timing, writes, multi-port reads,
// out-of-range handling, busy lockout, async reset abort and same-cycle read/write.
module tb_fcc_label_grid_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_start;
  logic        busy, clr_done;
  logic        we;
  logic [7:0]  wr_row;
  logic [4:0]  wr_col;
  logic [15:0] wr_label;
  logic        wr_is_ground;
  logic        wr_err;
  logic [1:0]  rd_req;
  logic [15:0] rd_row;
  logic [9:0]  rd_col;
  logic [1:0]  rd_valid;
  logic [31:0] rd_label;
  logic [1:0]  rd_is_ground;
  logic [1:0]  rd_oob;

  int checks   = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  fcc_label_grid_mem dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .we(we), .wr_row(wr_row), .wr_col(wr_col), .wr_label(wr_label),
    .wr_is_ground(wr_is_ground), .wr_err(wr_err),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid),
    .rd_label(rd_label), .rd_is_ground(rd_is_ground), .rd_oob(rd_oob)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [7:0] r, input logic [4:0] c,
                        input logic [15:0] l, input logic g);
    we = en; wr_row = r; wr_col = c; wr_label = l; wr_is_ground = g;
  endtask

  task automatic set_rd(input logic [1:0] req, input logic [7:0] r1, input logic [4:0] c1,
                        input logic [7:0] r0, input logic [4:0] c0);
    rd_req = req; rd_row = {r1, r0}; rd_col = {c1, c0};
  endtask

  // Counts edges until busy drops, starting from an already-elapsed count.
  task automatic wait_sweep(input int start, output int n);
    n = start;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_start = 1'b0;
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    chk("rst_wrerr", {31'd0, wr_err}, 32'd0);
    chk("rst_valid", {30'd0, rd_valid}, 32'd0);
    chk("rst_label", rd_label, 32'd0);
    chk("rst_oob", {30'd0, rd_oob}, 32'd0);

    rst_n = 1'b1;
    wait_sweep(0, cnt);
    chk("sweep1_len", cnt, 32'd900);
    chk("sweep1_done", {31'd0, clr_done}, 32'd1);

    set_rd(2'b11, 8'd29, 5'd29, 8'd0, 5'd0);
    tick();
    chk("done_pulse", {31'd0, clr_done}, 32'd0);
    chk("clr_valid", {30'd0, rd_valid}, 32'd3);
    chk("clr_label", rd_label, 32'd0);
    chk("clr_gnd", {30'd0, rd_is_ground}, 32'd0);

    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    set_wr(1'b1, 8'd3, 5'd7, 16'h1234, 1'b1);
    tick();
    chk("wr_ok_err", {31'd0, wr_err}, 32'd0);
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    set_rd(2'b11, 8'd3, 5'd7, 8'd3, 5'd7);
    tick();
    chk("rd37_valid", {30'd0, rd_valid}, 32'd3);
    chk("rd37_label", rd_label, 32'h12341234);
    chk("rd37_gnd", {30'd0, rd_is_ground}, 32'd3);
    chk("rd37_oob", {30'd0, rd_oob}, 32'd0);

    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    tick();
    chk("hold_valid", {30'd0, rd_valid}, 32'd0);
    chk("hold_label", rd_label, 32'h12341234);

    set_wr(1'b1, 8'd30, 5'd0, 16'hDEAD, 1'b1);
    tick();
    chk("oob_row_err", {31'd0, wr_err}, 32'd1);
    set_wr(1'b1, 8'd0, 5'd30, 16'hBEEF, 1'b1);
    tick();
    chk("oob_col_err", {31'd0, wr_err}, 32'd1);
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    // (0,30) would alias (1,0) if range checking were missing
    set_rd(2'b11, 8'd1, 5'd0, 8'd30, 5'd0);
    tick();
    chk("err_clear", {31'd0, wr_err}, 32'd0);
    chk("oob_valid", {30'd0, rd_valid}, 32'd3);
    chk("oob_flag", {30'd0, rd_oob}, 32'd1);
    chk("oob_label", rd_label, 32'd0);
    chk("oob_gnd", {30'd0, rd_is_ground}, 32'd0);

    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    set_wr(1'b1, 8'd5, 5'd5, 16'hAAAA, 1'b0);
    tick();
    set_wr(1'b1, 8'd5, 5'd5, 16'hBBBB, 1'b1);
    set_rd(2'b01, 8'd0, 5'd0, 8'd5, 5'd5);
    tick();
`ifdef FCC_MEM_BYPASS_EN
    chk("rw_label", {16'd0, rd_label[15:0]}, 32'h0000BBBB);
    chk("rw_gnd", {31'd0, rd_is_ground[0]}, 32'd1);
`else
    chk("rw_label", {16'd0, rd_label[15:0]}, 32'h0000AAAA);
    chk("rw_gnd", {31'd0, rd_is_ground[0]}, 32'd0);
`endif
    chk("rw_valid", {30'd0, rd_valid}, 32'd1);
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    tick();
    chk("rw_after", {16'd0, rd_label[15:0]}, 32'h0000BBBB);

    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd1);
    set_wr(1'b1, 8'd3, 5'd7, 16'h7777, 1'b1);
    set_rd(2'b11, 8'd3, 5'd7, 8'd5, 5'd5);
    tick();
    chk("busy_wrerr", {31'd0, wr_err}, 32'd1);
    chk("busy_valid", {30'd0, rd_valid}, 32'd0);
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_sweep(2, cnt);
    chk("sweep2_len", cnt, 32'd900);
    chk("sweep2_done", {31'd0, clr_done}, 32'd1);
    set_rd(2'b11, 8'd3, 5'd7, 8'd5, 5'd5);
    tick();
    chk("cleared_lbl", rd_label, 32'd0);
    chk("cleared_gnd", {30'd0, rd_is_ground}, 32'd0);

    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    set_wr(1'b1, 8'd2, 5'd2, 16'h5A5A, 1'b1);
    tick();
    set_wr(1'b0, 8'd0, 5'd0, 16'h0, 1'b0);
    set_rd(2'b11, 8'd2, 5'd2, 8'd2, 5'd2);
    tick();
    chk("pre_rst_lbl", rd_label, 32'h5A5A5A5A);
    set_rd(2'b00, 8'd0, 5'd0, 8'd0, 5'd0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (450) tick();
    rst_n = 1'b0;
    #2;
    chk("async_label", rd_label, 32'd0);
    chk("async_gnd", {30'd0, rd_is_ground}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    wait_sweep(0, cnt);
    chk("sweep3_len", cnt, 32'd900);
    chk("sweep3_done", {31'd0, clr_done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
